// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch sequencer
// and instruction memory.
interface pc_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ready,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output rdata
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and two-phase fetch sequencer: request a word, then hold
// it for decode until accepted, then step or redirect the PC.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   pc_fetch_unit_if.master    imem,
   output logic [31:0]        adder_first,
   output logic [31:0]        adder_second,
   input  logic [31:0]        pc_plus4,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   input  logic               jump,
   input  logic [31:0]        jump_target,
   input  logic               stall,
   output logic [31:0]        pc_out,
   output logic [31:0]        instr,
   output logic               instr_valid,
   output logic               misalign
);

   typedef enum logic [0:0] {
      FETCH,
      DELIVER
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;

   logic        redirect;
   logic [31:0] raw_tgt;

   // Jump wins over branch; both may be asserted together.
   always_comb begin
      redirect = 1'b1;
      raw_tgt  = pc_plus4;
      priority case (1'b1)
         jump:         raw_tgt = jump_target;
         branch_taken: raw_tgt = branch_target;
         default: begin
            redirect = 1'b0;
            raw_tgt  = pc_plus4;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mis_d   = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (imem.ready) begin
               instr_d = imem.rdata;
               valid_d = 1'b1;
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            if (!stall) begin
               pc_d    = redirect ? {raw_tgt[31:2], 2'b00}
                                  : raw_tgt;
               mis_d   = redirect && (raw_tgt[1:0] != 2'b00);
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   // Request is withheld during the reset cycle itself.
   assign imem.req     = (state_q == FETCH) && !reset;
   assign imem.addr    = pc_q;

   assign adder_first  = pc_q;
   assign adder_second = 32'd4;

   assign pc_out      = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign misalign    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized check of pc_fetch_unit against a
// transaction-level model of fetch/deliver behaviour.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] adder_first, adder_second, pc_plus4;
   logic        branch_taken, jump, stall;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_out, instr;
   logic        instr_valid, misalign;

   pc_fetch_unit_if imem ();

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem         (imem.master),
      .adder_first  (adder_first),
      .adder_second (adder_second),
      .pc_plus4     (pc_plus4),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .stall        (stall),
      .pc_out       (pc_out),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .misalign     (misalign)
   );

   // External 32-bit Adder
   assign pc_plus4 = adder_first + adder_second;

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Model: word held for decode or not, plus visible outputs.
   logic        m_have;
   logic [31:0] m_pc, m_instr;
   logic        m_valid, m_mis;

   task automatic chk(string tag, logic [31:0] obs,
                      logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("pc_out", pc_out, m_pc);
      chk("adder_first", adder_first, m_pc);
      chk("adder_second", adder_second, 32'd4);
      chk("instr", instr, m_instr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
      chk("imem_req", {31'b0, imem.req},
          {31'b0, (!reset && !m_have)});
      if (!reset && !m_have)
         chk("imem_addr", imem.addr, m_pc);
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      logic        redir;
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0;
         m_valid = 1'b0; m_mis = 1'b0; m_have = 1'b0;
      end else if (!m_have) begin
         m_mis = 1'b0;
         if (imem.ready) begin
            m_instr = imem.rdata;
            m_valid = 1'b1;
            m_have  = 1'b1;
         end
      end else if (stall) begin
         m_mis = 1'b0;
      end else begin
         redir = jump || branch_taken;
         tgt = jump ? jump_target :
               branch_taken ? branch_target : m_pc + 32'd4;
         m_mis   = redir && (tgt % 4 != 0);
         m_pc    = tgt - (tgt % 4);
         m_valid = 1'b0;
         m_have  = 1'b0;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic quiet();
      jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      jump_target = 32'h0; branch_target = 32'h0;
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      imem.ready = 1'b1;
      imem.rdata = 32'h1111_0000;
      m_have = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0;

      step();
      step();
      chk("reset_pc", pc_out, 32'h0);
      chk("reset_valid", {31'b0, instr_valid}, 32'h0);

      // Cycle 0: fetching at PC 0
      reset = 1'b0;
      #1;
      check_all();
      chk("c0_req", {31'b0, imem.req}, 32'h1);
      for (int c = 1; c <= 5; c++) begin
         imem.rdata = 32'h1111_0000 + c;
         step();
         if (c == 1) chk("c1_valid", {31'b0, instr_valid}, 32'h1);
         if (c == 2) chk("c2_pc", pc_out, 32'h4);
         if (c == 3) chk("c3_valid", {31'b0, instr_valid}, 32'h1);
         if (c == 4) chk("c4_pc", pc_out, 32'h8);
      end
      chk("c5_valid", {31'b0, instr_valid}, 32'h1);

      // Stall in DELIVER at PC 8 with a branch pending
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
      repeat (4) step();
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_instr", instr, 32'h1111_0005);
      stall = 1'b0;
      step();
      chk("branch_after_stall", pc_out, 32'h100);

      // Memory wait of three cycles
      quiet();
      imem.ready = 1'b0; imem.rdata = 32'hBAD0_BAD0;
      repeat (3) step();
      chk("wait_pc", pc_out, 32'h100);
      imem.ready = 1'b1; imem.rdata = 32'h2008_0005;
      step();
      chk("wait_instr", instr, 32'h2008_0005);

      // Jump beats branch, misaligned target
      jump = 1'b1; jump_target = 32'h0040_0002;
      branch_taken = 1'b1; branch_target = 32'h200;
      step();
      chk("jump_pc", pc_out, 32'h0040_0000);
      chk("jump_mis", {31'b0, misalign}, 32'h1);
      quiet();
      step();
      chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
      branch_taken = 1'b1; branch_target = 32'h200;
      step();
      chk("branch_pc", pc_out, 32'h200);
      chk("branch_nomis", {31'b0, misalign}, 32'h0);

      // Wrap-around through 32'hFFFF_FFFC
      quiet();
      step();
      jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      step();
      quiet();
      step();
      step();
      chk("wrap_pc", pc_out, 32'h0);

      // Reset while a response is returned in FETCH
      step();
      step();
      imem.rdata = 32'hDEAD_BEEF;
      reset = 1'b1;
      step();
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      reset = 1'b0;
      imem.rdata = 32'h0000_00AA;
      step();
      chk("no_deadbeef", instr, 32'h0000_00AA);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 39) == 0);
         imem.ready    = $urandom_range(0, 1) == 1;
         imem.rdata    = $urandom;
         stall         = ($urandom_range(0, 2) == 0);
         jump          = ($urandom_range(0, 4) == 0);
         branch_taken  = ($urandom_range(0, 3) == 0);
         jump_target   = $urandom;
         branch_target = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the MIPS datapath. It owns the PC, drives the 32-bit `Adder` operands (PC and constant 4), and consumes the adder's `sum` as the sequential next-PC. It selects between PC+4, branch target and jump target, and runs a request/ready handshake with instruction memory. Each fetched word goes to the decode stage with a valid flag and stall back-pressure.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1, single clock, all state updates on rising edge.
- `reset` in 1, synchronous, active-high.
- `adder_first` out 32, operand to `Adder.first`; always equals `pc_out`.
- `adder_second` out 32, operand to `Adder.second`; constant 32'd4.
- `pc_plus4` in 32, from `Adder.sum` (combinational PC+4).
- `branch_taken` in 1, redirect to `branch_target`.
- `branch_target` in 32, branch destination byte address.
- `jump` in 1, redirect to `jump_target`; has priority over branch.
- `jump_target` in 32, jump destination byte address.
- `stall` in 1, decode cannot accept; hold the current instruction.
- `imem_req` out 1, fetch request to instruction memory.
- `imem_addr` out 32, fetch address; equals `pc_out` while `imem_req`.
- `imem_ready` in 1, memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32, fetched instruction word.
- `pc_out` out 32, current PC.
- `instr` out 32, registered instruction for decode.
- `instr_valid` out 1, `instr` and `pc_out` are a valid pair.
- `misalign` out 1, one-cycle pulse: the selected redirect target had bits [1:0] != 0.

## Operation
- States: FETCH, DELIVER.
- Reset, from any state: `pc_out`=RESET_PC, state=FETCH, `instr`=0, `instr_valid`=0, `misalign`=0. `imem_req` is 0 during the reset cycle.
- FETCH:
  - Drive `imem_req`=1, `imem_addr`=`pc_out`.
  - On `imem_ready`: register `imem_rdata` into `instr`, set `instr_valid`, go to DELIVER.
  - Otherwise stay in FETCH. `pc_out` does not change.
- DELIVER:
  - `imem_req`=0, `instr_valid`=1.
  - If `stall`: hold everything. Redirect inputs are ignored.
  - If not `stall`: load next PC, clear `instr_valid`, go to FETCH.
- Next-PC priority: `jump` → `jump_target`; else `branch_taken` → `branch_target`; else `pc_plus4`.
- Redirect targets are loaded with bits [1:0] forced to 00. If the raw target had nonzero [1:0], `misalign` pulses for exactly one cycle, aligned with the PC update.
- Redirect inputs are sampled only on the DELIVER-and-not-stalled cycle. In FETCH they have no effect.
- `imem_ready` in DELIVER or during reset is ignored. `imem_rdata` is don't-care when `imem_ready`=0.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000). The block performs no addition itself.

## Timing
- Reset deasserted at edge 0: FETCH with `imem_req`=1 in cycle 0.
- `imem_ready` in cycle k → `instr_valid`=1 from cycle k+1.
- No stall → new PC visible in cycle k+2 and `imem_req` reasserted in cycle k+2.
- Peak throughput: one instruction per 2 cycles (ready returned in the same cycle as the request).
- `stall` held N cycles in DELIVER: `instr`, `pc_out` and `instr_valid` stay stable for N extra cycles.
- `adder_first` follows `pc_out` with zero latency. `pc_plus4` must settle within the same cycle.
- Reset asserted mid-fetch or mid-stall: the next edge applies the reset values; any pending memory response is discarded.

## Test plan
- Reset with RESET_PC=0, `imem_ready` tied 1, no stall:
  - `pc_out` sequence is 0, 4, 8, 12.
  - `instr_valid` is 0 at cycle 0 and 1 at cycles 1, 3, 5.
  - `adder_second`=4 throughout.
- Memory wait: `imem_ready` low for 3 cycles, then high with `imem_rdata`=32'h2008_0005 → `instr`=32'h2008_0005 and `instr_valid` one cycle later; `pc_out` unchanged throughout the wait.
- Stall: in DELIVER with `pc_out`=8, hold `stall` for 4 cycles with `branch_taken`=1 and target 32'h100 → `instr` and `pc_out`=8 are held, and the branch is ignored while stalled. Release `stall` with the branch still asserted → `pc_out`=32'h100.
- Priority and alignment:
  - `jump`=1 to 32'h0040_0002 together with `branch_taken`=1 to 32'h200 → `pc_out`=32'h0040_0000 and a one-cycle `misalign` pulse.
  - Branch alone to 32'h200 → `pc_out`=32'h200 with no `misalign`.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, `imem_ready`=1 → next `pc_out`=32'h0000_0000.
- Reset mid-operation: assert `reset` in FETCH while `imem_ready`=1 with `imem_rdata`=32'hDEAD_BEEF → `instr`=0, `instr_valid`=0, `pc_out`=RESET_PC the next cycle, and the word is never delivered.
